// File: rtl/adder_arb_pkg.sv
// Shared types and encodings for the round-robin adder arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic       OP_ADD  = 1'b0;
    localparam logic       OP_SUB  = 1'b1;
    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the requesters (master) and the arbiter (slave).
interface adder_arbiter_if #(
    parameter int unsigned BUS = 4,
    parameter int unsigned REQ = 2,
    parameter int unsigned IDW = 1
);
    logic [REQ-1:0]          req_valid;
    logic [REQ-1:0][BUS-1:0] req_a;
    logic [REQ-1:0][BUS-1:0] req_b;
    logic [REQ-1:0]          req_op;
    logic [REQ-1:0]          req_ready;
    logic [REQ-1:0]          resp_valid;
    logic [REQ-1:0]          resp_ready;
    logic [IDW-1:0]          resp_id;
    logic [BUS-1:0]          resp_result;
    logic                    resp_overflow;
    logic                    resp_zero;
    logic                    resp_negative;
    logic                    resp_carry;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result,
               resp_overflow, resp_zero, resp_negative, resp_carry, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result,
               resp_overflow, resp_zero, resp_negative, resp_carry, busy
    );
endinterface

// File: rtl/adder.sv
// Add/subtract datapath with overflow, zero, negative and carry-out flags.
module adder
    import adder_arb_pkg::*;
#(
    parameter int unsigned BUS = 4
) (
    input  logic [BUS-1:0] i_a,
    input  logic [BUS-1:0] i_b,
    input  logic [1:0]     i_sel,
    output logic [BUS-1:0] o_result,
    output logic           o_overflow,
    output logic           o_zero,
    output logic           o_negative,
    output logic           o_carry_out
);
    logic           w_sub;
    logic [BUS-1:0] w_b;
    logic [BUS:0]   w_sum;

    // Subtract as a + ~b + 1, so carry_out means "no borrow".
    assign w_sub       = (i_sel == SEL_SUB);
    assign w_b         = w_sub ? ~i_b : i_b;
    assign w_sum       = {1'b0, i_a} + {1'b0, w_b} + {{BUS{1'b0}}, w_sub};
    assign o_result    = w_sum[BUS-1:0];
    assign o_carry_out = w_sum[BUS];
    assign o_overflow  = (i_a[BUS-1] == w_b[BUS-1]) && (o_result[BUS-1] != i_a[BUS-1]);
    assign o_zero      = (o_result == '0);
    assign o_negative  = o_result[BUS-1];
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request after the pointer, wrapping modulo REQ.
module rr_arbiter #(
    parameter int unsigned REQ = 2,
    parameter int unsigned IDW = 1
) (
    input  logic [REQ-1:0] i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [REQ-1:0] o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);
    logic [IDW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int unsigned k = 1; k <= REQ; k++) begin
            w_cand = IDW'((32'(i_ptr) + k) % REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between REQ requesters: arbitrate, execute, hold response until accepted.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned BUS = 4,
    parameter int unsigned REQ = 2,
    parameter int unsigned IDW = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_arbiter_if.slave  io_bus
);
    state_e         r_state, w_state_d;
    logic [IDW-1:0] r_ptr, r_id;
    logic [BUS-1:0] r_a, r_b, r_result;
    logic           r_op, r_ovf, r_zero, r_neg, r_carry;

    logic [REQ-1:0] w_gnt, w_req_ready, w_resp_valid;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic [1:0]     w_sel;
    logic [BUS-1:0] w_result;
    logic           w_ovf, w_zero, w_neg, w_carry;

    rr_arbiter #(
        .REQ (REQ),
        .IDW (IDW)
    ) u_rr (
        .i_req (io_bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_sel = (r_op == OP_SUB) ? SEL_SUB : SEL_ADD;

    adder #(
        .BUS (BUS)
    ) u_adder (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_sel       (w_sel),
        .o_result    (w_result),
        .o_overflow  (w_ovf),
        .o_zero      (w_zero),
        .o_negative  (w_neg),
        .o_carry_out (w_carry)
    );

    always_comb begin
        w_state_d   = r_state;
        w_req_ready = '0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_req_ready = w_gnt;
                    w_state_d   = EXEC;
                end
            end
            EXEC:    w_state_d = RESP;
            RESP:    if (io_bus.resp_ready[r_id]) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_resp_valid = '0;
        if (r_state == RESP) w_resp_valid[r_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= IDW'(REQ - 1);
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == IDLE && w_any) begin
                r_a   <= io_bus.req_a[w_idx];
                r_b   <= io_bus.req_b[w_idx];
                r_op  <= io_bus.req_op[w_idx];
                r_id  <= w_idx;
                r_ptr <= w_idx;
            end
            if (r_state == EXEC) begin
                r_result <= w_result;
                r_ovf    <= w_ovf;
                r_zero   <= w_zero;
                r_neg    <= w_neg;
                r_carry  <= w_carry;
            end
        end
    end

    assign io_bus.req_ready     = w_req_ready;
    assign io_bus.resp_valid    = w_resp_valid;
    assign io_bus.resp_id       = r_id;
    assign io_bus.resp_result   = r_result;
    assign io_bus.resp_overflow = r_ovf;
    assign io_bus.resp_zero     = r_zero;
    assign io_bus.resp_negative = r_neg;
    assign io_bus.resp_carry    = r_carry;
    assign io_bus.busy          = (r_state != IDLE);
endmodule
